// File: rtl/mul_seq_32bit.sv
// Sequential 32x32 shift-add multiplier (32 iterations through one ripple adder).
// Optional signed support is enabled by defining MUL_SIGNED_EN (adds signed_op port and FIX state).

module adder_32bit (
   input  logic [31:0] i_x,
   input  logic [31:0] i_y,
   output logic [31:0] o_sum
);
   logic [31:0] w_c;

   assign w_c[0] = 1'b0;

   for (genvar gi = 0; gi < 32; gi++) begin : g_fa
      assign o_sum[gi] = i_x[gi] ^ i_y[gi] ^ w_c[gi];
      if (gi < 31) begin : g_carry
         assign w_c[gi+1] = (i_x[gi] & i_y[gi]) | (w_c[gi] & (i_x[gi] ^ i_y[gi]));
      end
   end
endmodule

module mul_seq_32bit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
`ifdef MUL_SIGNED_EN
   input  logic        signed_op,
`endif
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] product,
   output logic        busy
);

`ifdef MUL_SIGNED_EN
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

   state_t      r_state;
   state_t      w_state_nxt;
   logic [63:0] r_p;
   logic [31:0] r_mcand;
   logic [4:0]  r_cnt;
   logic [63:0] r_product;
   logic        w_last;

   logic [31:0] w_sum;
   logic        w_carry;
   logic [63:0] w_p_step;
   logic [31:0] w_mcand_in;
   logic [31:0] w_mplier_in;

`ifdef MUL_SIGNED_EN
   logic        r_neg;
   logic        w_neg_in;
   logic [63:0] w_p_fix;

   function automatic logic [31:0] abs32(input logic signed [31:0] v);
      // -(0x80000000) wraps to 0x80000000, which is the correct magnitude when read unsigned
      return v[31] ? 32'(-v) : 32'(v);
   endfunction

   assign w_mcand_in  = signed_op ? abs32(a) : a;
   assign w_mplier_in = signed_op ? abs32(b) : b;
   assign w_neg_in    = signed_op & (a[31] ^ b[31]);
   assign w_p_fix     = r_neg ? (~r_p + 64'd1) : r_p;
`else
   assign w_mcand_in  = a;
   assign w_mplier_in = b;
`endif

   adder_32bit u_adder (
      .i_x   (r_p[63:32]),
      .i_y   (r_mcand),
      .o_sum (w_sum)
   );

   // The adder has no carry port, so recover carry-out from the bit-31 operands and sum.
   assign w_carry  = (r_p[63] & r_mcand[31]) | ((r_p[63] | r_mcand[31]) & ~w_sum[31]);
   assign w_p_step = r_p[0] ? {w_carry, w_sum, r_p[31:1]} : {1'b0, r_p[63:1]};
   assign w_last   = (r_cnt == 5'd31);
   assign product  = r_product;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b1;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) w_state_nxt = S_RUN;
         end
         S_RUN: begin
`ifdef MUL_SIGNED_EN
            if (w_last) w_state_nxt = S_FIX;
`else
            if (w_last) w_state_nxt = S_DONE;
`endif
         end
`ifdef MUL_SIGNED_EN
         S_FIX: w_state_nxt = S_DONE;
`endif
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_p       <= 64'd0;
         r_mcand   <= 32'd0;
         r_cnt     <= 5'd0;
         r_product <= 64'd0;
`ifdef MUL_SIGNED_EN
         r_neg     <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_mcand <= w_mcand_in;
                  r_p     <= {32'd0, w_mplier_in};
                  r_cnt   <= 5'd0;
`ifdef MUL_SIGNED_EN
                  r_neg   <= w_neg_in;
`endif
               end
            end
            S_RUN: begin
               r_p   <= w_p_step;
               r_cnt <= r_cnt + 5'd1;
`ifndef MUL_SIGNED_EN
               if (w_last) r_product <= w_p_step;
`endif
            end
`ifdef MUL_SIGNED_EN
            S_FIX: begin
               r_p       <= w_p_fix;
               r_product <= w_p_fix;
            end
`endif
            default: ;
         endcase
      end
   end

endmodule
